// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: early pixel coordinates plus
// hsync/vsync/de delayed by PIPE_DELAY pixel strobes to match renderer latency.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int HSYNC_POL  = 0,
    parameter int VSYNC_POL  = 0,
    parameter int PIPE_DELAY = 0,
    parameter int COORD_W    = 10,
    parameter int FRAME_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    output logic [COORD_W-1:0] px_x,
    output logic [COORD_W-1:0] px_y,
    output logic               px_active,
    output logic               vblank,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count,
    output logic               hsync,
    output logic               vsync,
    output logic               de
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST      = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST      = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT_END   = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_END   = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] H_SYNC_BEG  = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] H_SYNC_END  = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] V_SYNC_BEG  = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] V_SYNC_END  = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_POL = (HSYNC_POL != 0);
    localparam logic VS_POL = (VSYNC_POL != 0);

    // Elaboration-time parameter sanity checks
    if (H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
        V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_porch
        $error("vga_timing_gen: porch and sync widths must be non-zero");
    end
    if (H_ACTIVE <= 0 || V_ACTIVE <= 0) begin : g_bad_active
        $error("vga_timing_gen: active area must be non-empty");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 8) begin : g_bad_delay
        $error("vga_timing_gen: PIPE_DELAY must be in 0..8");
    end
    if (COORD_W < 1 || COORD_W > 31 ||
        longint'(H_TOTAL) > (longint'(1) << COORD_W) ||
        longint'(V_TOTAL) > (longint'(1) << COORD_W)) begin : g_bad_coord
        $error("vga_timing_gen: COORD_W too narrow for H_TOTAL/V_TOTAL");
    end
    if (FRAME_W < 1) begin : g_bad_frame
        $error("vga_timing_gen: FRAME_W must be at least 1");
    end
    if (HSYNC_POL < 0 || HSYNC_POL > 1 || VSYNC_POL < 0 || VSYNC_POL > 1) begin : g_bad_pol
        $error("vga_timing_gen: sync polarity must be 0 or 1");
    end

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               h_wrap;
    logic               v_wrap;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            h_cnt <= h_wrap ? '0 : h_cnt + COORD_W'(1);
            if (h_wrap) begin
                v_cnt <= v_wrap ? '0 : v_cnt + COORD_W'(1);
            end
        end
    end

    logic act_c;
    logic vb_c;
    logic rh_c;
    logic rv_c;

    always_comb begin
        act_c = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        vb_c  = (v_cnt >= V_ACT_END);
        rh_c  = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        rv_c  = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    end

    logic raw_h;
    logic raw_v;

    // Stage 0: registered view of the counters, one strobe behind them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_x      <= '0;
            px_y      <= '0;
            px_active <= 1'b0;
            vblank    <= 1'b0;
            raw_h     <= 1'b0;
            raw_v     <= 1'b0;
        end else if (pix_en) begin
            px_x      <= h_cnt;
            px_y      <= v_cnt;
            px_active <= act_c;
            vblank    <= vb_c;
            raw_h     <= rh_c;
            raw_v     <= rv_c;
        end
    end

    // Strobes recompute every clk so they drop after one cycle even without pix_en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= pix_en && (h_cnt == '0);
            frame_start <= pix_en && (h_cnt == '0) && (v_cnt == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count <= '0;
        end else if (pix_en && h_wrap && v_wrap) begin
            frame_count <= frame_count + FRAME_W'(1);
        end
    end

    logic raw_h_d;
    logic raw_v_d;

    if (PIPE_DELAY == 0) begin : g_no_delay
        assign raw_h_d = raw_h;
        assign raw_v_d = raw_v;
        assign de      = px_active;
    end else begin : g_delay
        localparam int DW = 3 * PIPE_DELAY;
        logic [DW-1:0] dly;

        // Packed shift register; oldest entry sits in the top three bits
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dly <= '0;
            end else if (pix_en) begin
                dly <= DW'({dly, raw_h, raw_v, px_active});
            end
        end

        assign {raw_h_d, raw_v_d, de} = dly[DW-1 -: 3];
    end

    assign hsync = ~(raw_h_d ^ HS_POL);
    assign vsync = ~(raw_v_d ^ VS_POL);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a 14x8 raster: a per-cycle raster
// model plus directed measurements of sync widths, strobes and reset behaviour.
module tb_vga_timing_gen;

    localparam int H_ACT = 8;
    localparam int H_FP  = 2;
    localparam int H_SY  = 3;
    localparam int H_BP  = 1;
    localparam int V_ACT = 4;
    localparam int V_FP  = 1;
    localparam int V_SY  = 2;
    localparam int V_BP  = 1;
    localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
    localparam int F_TOT = H_TOT * V_TOT;

    logic clk;
    logic rst;
    logic pix_en;

    logic [3:0]  x0, y0;
    logic        act0, vb0, ls0, fs0, hs0, vs0, de0;
    logic [15:0] fc0;
    logic [9:0]  x2, y2;
    logic        act2, vb2, ls2, fs2, hs2, vs2, de2;
    logic [1:0]  fc2;

    int checks = 0;
    int errors = 0;

    vga_timing_gen #(
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
        .HSYNC_POL(0), .VSYNC_POL(0), .PIPE_DELAY(0), .COORD_W(4), .FRAME_W(16)
    ) dut0 (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .px_x(x0), .px_y(y0), .px_active(act0), .vblank(vb0),
        .line_start(ls0), .frame_start(fs0), .frame_count(fc0),
        .hsync(hs0), .vsync(vs0), .de(de0)
    );

    vga_timing_gen #(
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
        .HSYNC_POL(0), .VSYNC_POL(0), .PIPE_DELAY(2), .COORD_W(10), .FRAME_W(2)
    ) dut2 (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .px_x(x2), .px_y(y2), .px_active(act2), .vblank(vb2),
        .line_start(ls2), .frame_start(fs2), .frame_count(fc2),
        .hsync(hs2), .vsync(vs2), .de(de2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    // Model: n = pix_en strobes since reset; stage 0 shows raster index n-1
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       act;
        logic       vb;
        logic       rh;
        logic       rv;
    } st_t;

    function automatic st_t stage_at(input int k);
        st_t s;
        int  x, y;
        s = '0;
        if (k >= 0) begin
            x     = k % H_TOT;
            y     = (k / H_TOT) % V_TOT;
            s.x   = 10'(x);
            s.y   = 10'(y);
            s.act = (x < H_ACT) && (y < V_ACT);
            s.vb  = (y >= V_ACT);
            s.rh  = (x >= H_ACT + H_FP) && (x < H_ACT + H_FP + H_SY);
            s.rv  = (y >= V_ACT + V_FP) && (y < V_ACT + V_FP + V_SY);
        end
        return s;
    endfunction

    int n = 0;
    bit strobe_last = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n           <= 0;
            strobe_last <= 1'b0;
        end else begin
            strobe_last <= pix_en;
            if (pix_en) n <= n + 1;
        end
    end

    always @(negedge clk) begin
        st_t s0, s2;
        int  k, fc;
        bit  ls, fs;
        k  = n - 1;
        s0 = stage_at(k);
        s2 = stage_at(k - 2);
        ls = strobe_last && (k >= 0) && (k % H_TOT == 0);
        fs = strobe_last && (k >= 0) && (k % F_TOT == 0);
        fc = n / F_TOT;
        chk("d0.px_x",  int'(x0),   int'(s0.x));
        chk("d0.px_y",  int'(y0),   int'(s0.y));
        chk("d0.act",   int'(act0), int'(s0.act));
        chk("d0.vblank",int'(vb0),  int'(s0.vb));
        chk("d0.ls",    int'(ls0),  int'(ls));
        chk("d0.fs",    int'(fs0),  int'(fs));
        chk("d0.fcnt",  int'(fc0),  fc % 65536);
        chk("d0.hsync", int'(hs0),  s0.rh ? 0 : 1);
        chk("d0.vsync", int'(vs0),  s0.rv ? 0 : 1);
        chk("d0.de",    int'(de0),  int'(s0.act));
        chk("d2.px_x",  int'(x2),   int'(s0.x));
        chk("d2.px_y",  int'(y2),   int'(s0.y));
        chk("d2.act",   int'(act2), int'(s0.act));
        chk("d2.vblank",int'(vb2),  int'(s0.vb));
        chk("d2.ls",    int'(ls2),  int'(ls));
        chk("d2.fs",    int'(fs2),  int'(fs));
        chk("d2.fcnt",  int'(fc2),  fc % 4);
        chk("d2.hsync", int'(hs2),  s2.rh ? 0 : 1);
        chk("d2.vsync", int'(vs2),  s2.rv ? 0 : 1);
        chk("d2.de",    int'(de2),  int'(s2.act));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    int  fs_cycle[$];
    int  fc2_at_fs[$];
    int  hs_low_l1, hs_min, hs_max, de_cnt, vs_low, vb_cnt, ls_cnt;
    int  h2_fall, h2_rise, de2x, de2y;
    bit  prev_hs2, prev_de2, found;
    int  hsl, lsb, last_x;

    initial begin
        rst    = 1'b1;
        pix_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.px_x",  int'(x0),  0);
        chk("rst.hsync", int'(hs0), 1);
        chk("rst.vsync", int'(vs2), 1);
        chk("rst.de",    int'(de2), 0);
        rst    = 1'b0;
        pix_en = 1'b1;

        // Continuous pixel strobes for just over five frames
        hs_low_l1 = 0; hs_min = 99; hs_max = -1; de_cnt = 0; vs_low = 0;
        vb_cnt = 0; ls_cnt = 0; h2_fall = -1; h2_rise = -1; de2x = -1; de2y = -1;
        prev_hs2 = 1'b1; prev_de2 = 1'b0;
        for (int i = 0; i < 570; i++) begin
            @(negedge clk);
            #1;
            if (i < F_TOT) begin
                de_cnt += int'(de0);
                vs_low += int'(!vs0);
                vb_cnt += int'(vb0);
                ls_cnt += int'(ls0);
                if (y0 == 4'd1 && !hs0) begin
                    hs_low_l1++;
                    if (int'(x0) < hs_min) hs_min = int'(x0);
                    if (int'(x0) > hs_max) hs_max = int'(x0);
                end
            end
            if (fs0) fs_cycle.push_back(i);
            if (fs2) fc2_at_fs.push_back(int'(fc2));
            if (h2_fall < 0 && prev_hs2 && !hs2) h2_fall = int'(x2);
            else if (h2_fall >= 0 && h2_rise < 0 && !prev_hs2 && hs2) h2_rise = int'(x2);
            if (de2x < 0 && !prev_de2 && de2) begin
                de2x = int'(x2);
                de2y = int'(y2);
            end
            prev_hs2 = hs2;
            prev_de2 = de2;
        end
        chk("hsync low clks line1", hs_low_l1, 3);
        chk("hsync low first px_x", hs_min, 10);
        chk("hsync low last px_x",  hs_max, 12);
        chk("de clks per frame",    de_cnt, 32);
        chk("vsync low per frame",  vs_low, 28);
        chk("vblank per frame",     vb_cnt, 56);
        chk("line_start per frame", ls_cnt, 8);
        chk("frame_start count",    fs_cycle.size(), 6);
        if (fs_cycle.size() >= 2) begin
            chk("first frame_start cycle", fs_cycle[0], 0);
            chk("frame_start period", fs_cycle[1] - fs_cycle[0], 112);
        end
        chk("d2 frame_start count", fc2_at_fs.size(), 6);
        if (fc2_at_fs.size() >= 5) begin
            chk("d2 fcnt at fs0", fc2_at_fs[0], 0);
            chk("d2 fcnt at fs1", fc2_at_fs[1], 1);
            chk("d2 fcnt at fs2", fc2_at_fs[2], 2);
            chk("d2 fcnt at fs3", fc2_at_fs[3], 3);
            chk("d2 fcnt at fs4", fc2_at_fs[4], 0);
        end
        chk("d2 hsync fall px_x", h2_fall, 12);
        chk("d2 hsync rise px_x", h2_rise, 1);
        chk("d2 de rise px_x", de2x, 2);
        chk("d2 de rise px_y", de2y, 0);

        // Mid-frame asynchronous reset at (5,2)
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            #1;
            if (x0 == 4'd5 && y0 == 4'd2) found = 1'b1;
        end
        chk("reached (5,2)", int'(found), 1);
        chk("fcnt before reset", int'(fc0), 5);
        #2;
        rst = 1'b1;
        #1;
        chk("async px_x",  int'(x0),  0);
        chk("async px_y",  int'(y0),  0);
        chk("async fcnt",  int'(fc0), 0);
        chk("async hsync", int'(hs2), 1);
        chk("async vsync", int'(vs0), 1);
        chk("async de",    int'(de0), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post-rst px_x", int'(x0),  0);
        chk("post-rst px_y", int'(y0),  0);
        chk("post-rst fs",   int'(fs0), 1);
        chk("post-rst fcnt", int'(fc0), 0);

        // Pixel pacing: one strobe every 4 clks
        rst    = 1'b1;
        pix_en = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        hsl = 0; lsb = 0; last_x = -1;
        for (int c = 0; c < 64; c++) begin
            if (c >= 1 && c <= 56) begin
                hsl += int'(!hs0);
                lsb += int'(ls0);
            end
            if (c == 56) last_x = int'(x0);
            pix_en = (c % 4 == 0);
            @(negedge clk);
            #1;
        end
        chk("paced hsync low clks", hsl, 12);
        chk("paced line_start clks", lsb, 1);
        chk("paced px_x end of line", last_x, 13);

        pix_en = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
